// File: rtl/pri_arb_pkg.sv
// Shared types and width helpers for the priority request ager and its slots.
package pri_arb_pkg;

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_UPD    = 2'd1,
    S_WAIT   = 2'd2,
    S_STABLE = 2'd3
  } ager_state_t;

  function automatic int pri_w(input int p);
    return (p > 1) ? $clog2(p) : 1;
  endfunction

  function automatic int age_w(input int a);
    return (a > 1) ? $clog2(a) : 1;
  endfunction

  localparam int P_DEF  = 16;
  localparam int PW_DEF = pri_w(P_DEF);

  typedef logic [PW_DEF-1:0] pri_t;

endpackage

// File: rtl/pri_age_slot.sv
// One requester slot: holds a pending request and ages its priority while the
// arbiter view is stable. Retire wins over an age step in the same cycle.
module pri_age_slot
  import pri_arb_pkg::*;
#(
  parameter  int P            = 16,
  parameter  int AGE_INTERVAL = 8,
  localparam int PW           = pri_w(P),
  localparam int AW           = age_w(AGE_INTERVAL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stable,
  input  logic          req_valid,
  input  logic [PW-1:0] req_pri,
  input  logic          granted,
  output logic [PW-1:0] pri,
  output logic          valid,
  output logic          changed,
  output logic          sat
);

  logic          valid_q, valid_d;
  logic [PW-1:0] pri_q, pri_d;
  logic [AW-1:0] age_q, age_d;
  logic          accept_s, retire_s, age_en_s, step_s;

  // Event decode and next-state selection; retire has priority over aging.
  always_comb begin
    accept_s = stable && req_valid && !valid_q;
    retire_s = stable && granted && valid_q;
    age_en_s = stable && valid_q && !retire_s && (pri_q != PW'(P - 1));
    step_s   = age_en_s && (age_q == AW'(AGE_INTERVAL - 1));
    valid_d  = valid_q;
    pri_d    = pri_q;
    age_d    = age_q;
    if (retire_s) begin
      valid_d = 1'b0;
      pri_d   = '0;
      age_d   = '0;
    end else if (accept_s) begin
      valid_d = 1'b1;
      pri_d   = (req_pri == '0) ? PW'(1) : req_pri;
      age_d   = '0;
    end else if (step_s) begin
      pri_d = pri_q + PW'(1);
      age_d = '0;
    end else if (age_en_s) begin
      age_d = age_q + AW'(1);
    end else begin
      age_d = age_q;
    end
  end

  // Slot state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pri_q   <= '0;
      age_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pri_q   <= pri_d;
      age_q   <= age_d;
    end
  end

  assign pri     = valid_q ? pri_q : '0;
  assign valid   = valid_q;
  assign changed = accept_s || retire_s || step_s;
  assign sat     = valid_q && (pri_q == PW'(P - 1));

endmodule

// File: rtl/pri_req_ager.sv
// Request stage in front of the priority arbiter: N aging slots plus the
// update/settle handshake that keeps pri_req frozen while the select settles.
module pri_req_ager
  import pri_arb_pkg::*;
#(
  parameter  int N            = 4,
  parameter  int P            = 16,
  parameter  int AGE_INTERVAL = 8,
  parameter  int SETTLE       = 4,
  localparam int PW           = pri_w(P),
  localparam int CW           = (SETTLE > 1) ? $clog2(SETTLE) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  in_valid,
  input  logic [PW-1:0] in_pri [0:N-1],
  output logic [N-1:0]  in_ready,
  input  logic [N-1:0]  gnt,
  input  logic          any_gnt,
  input  logic          sel_ready,
  output logic [PW-1:0] pri_req [0:N-1],
  output logic          sel_update,
  output logic [N-1:0]  age_sat
);

  ager_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  valid_s;
  logic [N-1:0]  changed_s;
  logic          stable_s;

  assign stable_s = (state_q == S_STABLE);

  for (genvar i = 0; i < N; i++) begin : g_slot
    pri_age_slot #(
      .P            (P),
      .AGE_INTERVAL (AGE_INTERVAL)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .stable    (stable_s),
      .req_valid (in_valid[i]),
      .req_pri   (in_pri[i]),
      .granted   (any_gnt && gnt[i]),
      .pri       (pri_req[i]),
      .valid     (valid_s[i]),
      .changed   (changed_s[i]),
      .sat       (age_sat[i])
    );
  end

  // Next-state logic; the settle counter saturates at SETTLE-1 until sel_ready.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        state_d = S_UPD;
      end
      S_UPD: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = sel_ready ? S_STABLE : S_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STABLE: begin
        state_d = (|changed_s) ? S_UPD : S_STABLE;
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM and settle counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready   = ~valid_s & {N{stable_s}};
  assign sel_update = (state_q == S_UPD);

endmodule
